spike_rate_monitor: RTL and testbench



---
 rtl/spike_rate_monitor_if.sv | 12 +
 rtl/spike_rate_monitor.sv | 161 ++++++++++++++++
 tb/tb_spike_rate_monitor.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/spike_rate_monitor_if.sv
// Pin-side bundle of the spike rate monitor: neuron spike, control and status byte.
interface spike_rate_monitor_if;
    logic       spike;
    logic       en;
    logic [2:0] sel;
    logic [7:0] data_out;
    logic       rate_valid;
    logic       burst;

    modport master (output spike, en, sel, input data_out, rate_valid, burst);
    modport slave  (input spike, en, sel, output data_out, rate_valid, burst);
endinterface

// File: rtl/spike_rate_monitor.sv
// Spike onset rate counter, ISI meter and burst detector with a registered status byte.
// Optional ISI histogram (sel=4..7) is built when SPIKE_RATE_MONITOR_HIST_EN is defined.
module spike_rate_monitor #(
    parameter int WIN_LEN   = 1000,
    parameter int BURST_ISI = 20,
    parameter int BURST_MIN = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    spike_rate_monitor_if.slave mon
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_TRACK = 2'd1, S_BURST = 2'd2} fsm_t;

    typedef struct packed {
        logic       burst;
        logic       isi_valid;
        logic [1:0] state;
        logic [3:0] burst_len;
    } status_t;

    logic        spike_q;
    logic [15:0] win_cnt;
    logic [7:0]  spk_cnt, rate_reg, isi_cnt, isi_last, short_cnt, short_d;
    logic [7:0]  dout_q, mux_d, spk_sum;
    logic [3:0]  burst_len, blen_d;
    logic        rv_q, isi_valid, onset, terminal, isi_short, rate_vld;
    fsm_t        state, state_d;
    status_t     status;

    assign onset     = mon.spike & ~spike_q & mon.en;
    assign terminal  = (win_cnt == 16'(WIN_LEN - 1));
    assign isi_short = (int'(isi_cnt) <= BURST_ISI);
    assign spk_sum   = (spk_cnt == 8'hFF) ? 8'hFF : spk_cnt + {7'd0, onset};
    assign rate_vld  = rv_q & mon.en;

    assign status = '{burst: (state == S_BURST), isi_valid: isi_valid,
                      state: state, burst_len: burst_len};

    always_comb begin
        state_d = state;
        short_d = short_cnt;
        blen_d  = burst_len;
        if (mon.en) begin
            case (state)
                S_IDLE: begin
                    if (onset) begin
                        state_d = S_TRACK;
                        short_d = 8'd0;
                    end
                end
                S_TRACK: begin
                    if (onset && isi_valid) begin
                        if (isi_short) begin
                            short_d = short_cnt + 8'd1;
                            // the onset completing the run is the first spike of the burst
                            if (int'(short_d) == BURST_MIN) begin
                                state_d = S_BURST;
                                blen_d  = 4'd1;
                            end
                        end else begin
                            short_d = 8'd0;
                        end
                    end else if (!isi_short) begin
                        short_d = 8'd0;
                    end
                end
                S_BURST: begin
                    if (!isi_short) begin
                        state_d = S_TRACK;
                        short_d = 8'd0;
                    end else if (onset && burst_len != 4'hF) begin
                        blen_d = burst_len + 4'd1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

`ifdef SPIKE_RATE_MONITOR_HIST_EN
    logic [3:0][7:0] hist;
    logic [1:0]      bin;

    always_comb begin
        bin = 2'd3;
        if (isi_cnt <= 8'd8)        bin = 2'd0;
        else if (isi_cnt <= 8'd32)  bin = 2'd1;
        else if (isi_cnt <= 8'd128) bin = 2'd2;
    end

    // clear wins over a simultaneous increment
    always_ff @(posedge clk) begin
        if (!reset_n || rate_vld)
            hist <= '0;
        else if (onset && isi_valid && hist[bin] != 8'hFF)
            hist[bin] <= hist[bin] + 8'd1;
    end
`endif

    always_comb begin
        mux_d = 8'd0;
        case (mon.sel)
            3'd0:    mux_d = rate_reg;
            3'd1:    mux_d = isi_last;
            3'd2:    mux_d = status;
            3'd3:    mux_d = spk_cnt;
`ifdef SPIKE_RATE_MONITOR_HIST_EN
            default: mux_d = hist[mon.sel[1:0]];
`else
            default: mux_d = 8'd0;
`endif
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            spike_q   <= 1'b0;
            win_cnt   <= '0;
            spk_cnt   <= '0;
            rate_reg  <= '0;
            rv_q      <= 1'b0;
            isi_cnt   <= '0;
            isi_valid <= 1'b0;
            isi_last  <= '0;
            state     <= S_IDLE;
            short_cnt <= '0;
            burst_len <= '0;
            dout_q    <= '0;
        end else begin
            spike_q   <= mon.spike;
            dout_q    <= mux_d;
            rv_q      <= 1'b0;
            state     <= state_d;
            short_cnt <= short_d;
            burst_len <= blen_d;
            if (mon.en) begin
                if (terminal) begin
                    win_cnt  <= '0;
                    rate_reg <= spk_sum;
                    spk_cnt  <= '0;
                    rv_q     <= 1'b1;
                end else begin
                    win_cnt <= win_cnt + 16'd1;
                    spk_cnt <= spk_sum;
                end
                if (onset)
                    isi_cnt <= 8'd1;
                else if (isi_cnt != 8'hFF)
                    isi_cnt <= isi_cnt + 8'd1;
                if (onset) begin
                    if (isi_valid) isi_last <= isi_cnt;
                    isi_valid <= 1'b1;
                end
            end
        end
    end

    assign mon.data_out   = dout_q;
    assign mon.rate_valid = rate_vld;
    assign mon.burst      = (state == S_BURST);
endmodule

// File: tb/tb_spike_rate_monitor.sv
// Bench for spike_rate_monitor: directed scenarios plus random traffic against a reference model.
module tb_spike_rate_monitor;
    localparam int BI = 20;
    localparam int BM = 3;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       spike = 1'b0;
    logic       en = 1'b0;
    logic [2:0] sel = 3'd0;
    bit         chk_on = 1'b0;
    int         checks = 0;
    int         errors = 0;
    int         ons[$];

    always #5 clk = ~clk;

    spike_rate_monitor_if ifa ();
    spike_rate_monitor_if ifb ();
    assign ifa.spike = spike; assign ifa.en = en; assign ifa.sel = sel;
    assign ifb.spike = spike; assign ifb.en = en; assign ifb.sel = sel;

    spike_rate_monitor #(.WIN_LEN(16), .BURST_ISI(BI), .BURST_MIN(BM))
        dut_a (.clk(clk), .reset_n(reset_n), .mon(ifa));
    spike_rate_monitor #(.WIN_LEN(1000), .BURST_ISI(BI), .BURST_MIN(BM))
        dut_b (.clk(clk), .reset_n(reset_n), .mon(ifb));

    // Reference: time is the count of enabled cycles since reset; ISIs are timestamp differences.
    typedef struct {
        int ecyc, last_on, spk, rate, isi_last, fsm, short_n, blen, dout;
        bit have_on, spike_q, rv, isi_valid;
        bit [3:0][7:0] h;
    } mdl_t;

    mdl_t ma, mb;

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic mdl_t mdl_zero();
        mdl_t z;
        z.ecyc = 0; z.last_on = 0; z.spk = 0; z.rate = 0; z.isi_last = 0;
        z.fsm = 0; z.short_n = 0; z.blen = 0; z.dout = 0;
        z.have_on = 0; z.spike_q = 0; z.rv = 0; z.isi_valid = 0; z.h = '0;
        return z;
    endfunction

    function automatic mdl_t step(input mdl_t m, input bit sp, input bit e,
                                  input int sl, input bit rn, input int wl);
        mdl_t n;
        bit on;
        int isi, b;
        if (!rn) return mdl_zero();
        n = m;
        on = sp && !m.spike_q && e;
        n.spike_q = sp;
        isi = m.have_on ? sat(m.ecyc - m.last_on, 255) : sat(m.ecyc, 255);
        case (sl)
            0: n.dout = m.rate;
            1: n.dout = m.isi_last;
            2: n.dout = (m.fsm == 2 ? 128 : 0) + (m.isi_valid ? 64 : 0) + m.fsm * 16 + m.blen;
            3: n.dout = m.spk;
`ifdef SPIKE_RATE_MONITOR_HIST_EN
            default: n.dout = int'(m.h[sl - 4]);
`else
            default: n.dout = 0;
`endif
        endcase
        n.rv = 0;
        if (e) begin
            n.ecyc = m.ecyc + 1;
            if (m.ecyc % wl == wl - 1) begin
                n.rate = sat(m.spk + int'(on), 255);
                n.spk  = 0;
                n.rv   = 1;
            end else begin
                n.spk = sat(m.spk + int'(on), 255);
            end
            if (on) begin
                if (m.isi_valid) begin
                    n.isi_last = isi;
                    b = (isi <= 8) ? 0 : (isi <= 32) ? 1 : (isi <= 128) ? 2 : 3;
                    if (n.h[b] != 8'hFF) n.h[b] = n.h[b] + 8'd1;
                end
                n.isi_valid = 1;
                n.have_on   = 1;
                n.last_on   = m.ecyc;
            end
            case (m.fsm)
                0: if (on) begin n.fsm = 1; n.short_n = 0; end
                1: begin
                    if (on && m.isi_valid) begin
                        if (isi <= BI) begin
                            n.short_n = m.short_n + 1;
                            if (n.short_n == BM) begin n.fsm = 2; n.blen = 1; end
                        end else n.short_n = 0;
                    end else if (isi > BI) n.short_n = 0;
                end
                default: begin
                    if (isi > BI) begin n.fsm = 1; n.short_n = 0; end
                    else if (on) n.blen = sat(m.blen + 1, 15);
                end
            endcase
            if (m.rv) n.h = '0;
        end
        return n;
    endfunction

    always @(posedge clk) begin
        ma <= step(ma, spike, en, int'(sel), reset_n, 16);
        mb <= step(mb, spike, en, int'(sel), reset_n, 1000);
    end

    task automatic cmp(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        #1;
        if (chk_on) begin
            cmp("a_data_out", int'(ifa.data_out), ma.dout);
            cmp("a_rate_valid", int'(ifa.rate_valid), int'(ma.rv && en));
            cmp("a_burst", int'(ifa.burst), int'(ma.fsm == 2));
            cmp("b_data_out", int'(ifb.data_out), mb.dout);
            cmp("b_rate_valid", int'(ifb.rate_valid), int'(mb.rv && en));
            cmp("b_burst", int'(ifb.burst), int'(mb.fsm == 2));
        end
    end

    task automatic drive_seq(input int s, input int e);
        for (int c = s; c < e; c++) begin
            @(negedge clk);
            reset_n = 1'b1;
            spike = 1'b0;
            foreach (ons[k]) if (ons[k] == c) spike = 1'b1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        spike = 1'b0;
        en = 1'b1;
        @(negedge clk);
        #2;
        cmp("rst_data_out", int'(ifa.data_out), 0);
        cmp("rst_rate_valid", int'(ifa.rate_valid), 0);
        cmp("rst_burst", int'(ifa.burst), 0);
    endtask

    initial begin
        int hexp;
        bit dense;
        ma = mdl_zero();
        mb = mdl_zero();
        repeat (2) @(negedge clk);
        chk_on = 1'b1;

        // rate window: onsets at 0,4,8(3 wide),12
        do_reset();
        sel = 3'd0;
        ons = '{0, 4, 8, 9, 10, 12};
        drive_seq(0, 17);
        #2 cmp("rate_valid_at_16", int'(ifa.rate_valid), 1);
        drive_seq(17, 18);
        #2 cmp("rate_window_4", int'(ifa.data_out), 4);

        // reset mid-window discards partial count
        do_reset();
        ons = '{0, 2, 4, 6, 8};
        drive_seq(0, 10);
        do_reset();
        ons.delete();
        drive_seq(0, 17);
        #2 cmp("rst_mid_rate_valid", int'(ifa.rate_valid), 1);
        drive_seq(17, 18);
        #2 cmp("rst_mid_rate_zero", int'(ifa.data_out), 0);

        // onset on the terminal cycle belongs to the closing window
        do_reset();
        ons = '{3, 15};
        drive_seq(0, 18);
        #2 cmp("terminal_onset", int'(ifa.data_out), 2);

        // ISI measurement and saturation
        do_reset();
        sel = 3'd2;
        ons = '{10, 17, 300};
        drive_seq(0, 8);
        #2 cmp("isi_valid_early", int'(ifa.data_out[6]), 0);
        drive_seq(8, 18);
        sel = 3'd1;
        drive_seq(18, 20);
        #2 cmp("isi_7", int'(ifa.data_out), 7);
        drive_seq(20, 303);
        #2 cmp("isi_sat", int'(ifa.data_out), 255);

        // burst: six onsets 5 apart
        do_reset();
        sel = 3'd2;
        ons = '{0, 5, 10, 15, 20, 25};
        drive_seq(0, 16);
        #2 cmp("burst_before_4th", int'(ifa.burst), 0);
        drive_seq(16, 17);
        #2 cmp("burst_after_4th", int'(ifa.burst), 1);
        drive_seq(17, 31);
        #2 cmp("burst_status", int'(ifa.data_out), 8'hE3);
        drive_seq(31, 47);
        #2 cmp("burst_hold", int'(ifa.burst), 1);
        drive_seq(47, 48);
        #2 cmp("burst_fall", int'(ifa.burst), 0);
        drive_seq(48, 50);
        #2 cmp("burst_len_held", int'(ifa.data_out), 8'h53);

        // saturation: 300 onsets in a 1000-cycle window
        do_reset();
        sel = 3'd0;
        ons.delete();
        for (int i = 0; i < 300; i++) ons.push_back(2 * i);
        drive_seq(0, 1001);
        #2 cmp("b_rate_valid_1000", int'(ifb.rate_valid), 1);
        drive_seq(1001, 1002);
        #2 cmp("b_rate_sat", int'(ifb.data_out), 255);

        // enable gating
        do_reset();
        sel = 3'd3;
        ons = '{1, 3};
        drive_seq(0, 6);
        en = 1'b0;
        ons = '{8, 10, 12};
        drive_seq(6, 16);
        #2 cmp("en_spk_frozen", int'(ifa.data_out), 2);
        cmp("en_rate_valid_low", int'(ifa.rate_valid), 0);
        en = 1'b1;

        // histogram: ISIs 5, 20, 100, 200
        do_reset();
        ons = '{0, 5, 25, 125, 325};
        drive_seq(0, 327);
`ifdef SPIKE_RATE_MONITOR_HIST_EN
        hexp = 1;
`else
        hexp = 0;
`endif
        for (int i = 0; i < 4; i++) begin
            sel = 3'(4 + i);
            drive_seq(327 + 2 * i, 329 + 2 * i);
            #2 cmp($sformatf("hist_bin%0d", i), int'(ifb.data_out), hexp);
        end

        // random traffic
        ons.delete();
        dense = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (c % 250 == 0) dense = ($urandom_range(0, 1) == 1);
            reset_n = ($urandom_range(0, 599) != 0);
            en = ($urandom_range(0, 9) != 0);
            sel = 3'($urandom_range(0, 7));
            if (spike) spike = ($urandom_range(0, 1) == 1);
            else spike = dense ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 39) == 0);
        end
        @(negedge clk);
        #2;
        chk_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
